intersection_phase_scheduler: RTL and testbench
===============================================

// Module: intersection_phase_scheduler
// PURPOSE
//  Round-robin phase scheduler for a 4-approach intersection (NS, EW, SW_NE, WN_ES).
//  - Grants one green phase at a time from sensor requests.
//  - Enforces min/max green, yellow and all-red clearance times.
//  - Inserts a pedestrian walk phase on request; supports emergency-vehicle preemption.
//  - Drives the four 3-bit light buses directly; sits between road sensors and lamp drivers.
// PARAMETERS
//  GREEN_MIN  4   min green cycles once granted
//  GREEN_MAX  10  max green cycles while own request held
//  YELLOW_T   2   yellow cycles
//  ALLRED_T   1   all-red clearance cycles
//  WALK_T     3   pedestrian walk cycles (all lights red)
//  TW         8   timer width in bits; every *_T/GREEN_* must be < 2**TW
// PORTS
//  CLK            in   1   clock, all state changes on posedge
//  RST            in   1   synchronous, active-high reset
//  ns_traffic     in   1   request, phase 0 (level)
//  ew_traffic     in   1   request, phase 1
//  sw_ne_traffic  in   1   request, phase 2
//  wn_es_traffic  in   1   request, phase 3
//  ped_req        in   1   pedestrian button, 1-cycle pulse or level; latched
//  emerg_valid    in   1   emergency preemption active (level)
//  emerg_dir      in   2   phase index to preempt to; sampled when emerg_valid=1
//  ns_light       out  3   {red,yellow,green} one-hot, phase 0
//  ew_light       out  3   phase 1
//  sw_ne_light    out  3   phase 2
//  wn_es_light    out  3   phase 3
//  ped_walk       out  1   1 during WALK state
//  cur_phase      out  2   index of phase in GREEN/YELLOW (last served otherwise)
// BEHAVIOUR
//  Encoding: RED=3'b100, YELLOW=3'b010, GREEN=3'b001. Outputs registered, updated same edge as state.
//  Reset: state ALL_RED, timer=ALLRED_T, all lights RED, ped_walk=0, cur_phase=0,
//   rr pointer=0 (phase 0 highest priority), ped latch=0, preempt flag=0.
//  States: ALL_RED, GREEN, YELLOW, WALK.
//  Timer loads on state entry, decrements each cycle; "expired" = timer==1 on the deciding edge,
//   so a state loaded with N lasts exactly N cycles.
//  ALL_RED on expiry (priority order):
//   1 emerg_valid -> GREEN(emerg_dir), preempt=1.
//   2 ped latch set -> WALK(WALK_T), clear latch.
//   3 any request -> GREEN of first requesting phase at/after rr pointer (round robin).
//   4 none -> stay ALL_RED (timer held at 1; re-evaluated every cycle).
//  GREEN (phase p): end -> YELLOW(YELLOW_T) when any of:
//   - emerg_valid and emerg_dir!=p (immediate, ignores GREEN_MIN);
//   - preempt=1 and emerg_valid=0 (emergency over);
//   - preempt=0, cycles>=GREEN_MIN and (other request pending or ped latch or own request low);
//   - preempt=0, cycles==GREEN_MAX.
//   While preempt=1 and emerg_valid with emerg_dir==p, green held indefinitely (no GREEN_MAX).
//   emerg_valid rising with emerg_dir==p during normal green: set preempt=1, hold green.
//  YELLOW -> ALL_RED(ALLRED_T) on expiry; rr pointer <= p+1 mod 4; preempt cleared.
//  WALK -> ALL_RED(ALLRED_T) on expiry; ped_walk=1 only in WALK.
//  ped_req latched any cycle (incl. WALK); a press during WALK is served next round.
//  emerg_valid during WALK or YELLOW: sequence completes, preemption taken at next ALL_RED.
//  Invariant: at most one light bus non-RED; never GREEN->GREEN without YELLOW+ALL_RED.
//  RST asserted mid-phase: next edge forces reset state regardless of timer.
// STRUCTURE
//  Shared package/header: light encodings, state encodings, phase indices 0..3.
//  One sub-module: rr_pick4 (combinational: req[3:0], ptr[1:0] -> valid, idx[1:0]).
//  Timer, state register, latches and light decode in this module.
// TESTING (GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=2, ALLRED_T=1, WALK_T=3)
//  1 Reset, no requests for 20 cycles -> all lights 3'b100, ped_walk=0 throughout.
//  2 ns_traffic held alone -> ns GREEN 10 cycles, YELLOW 2, all-red 1, then ns GREEN again.
//  3 All four requests held -> greens in order ns,ew,sw_ne,wn_es, each exactly 4 cycles.
//  4 ped_req 1-cycle pulse during ns GREEN with ew request -> ns YELLOW after min green,
//    all-red, WALK 3 cycles (ped_walk=1, all RED), all-red, ew GREEN.
//  5 emerg_valid=1, emerg_dir=2 during cycle 2 of ew GREEN -> ew YELLOW next edge, all-red,
//    sw_ne GREEN held until emerg_valid drops, then YELLOW, all-red, wn_es served next.
//  6 RST pulsed mid-YELLOW -> next edge all RED, cur_phase=0; checker asserts one-non-RED invariant.

Source files
------------

// File: rtl/intersection_phase_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | intersection_phase_scheduler_pkg                                     |
// | Lamp encodings, phase indices and controller state type.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package intersection_phase_scheduler_pkg;

    localparam logic [2:0] c_lamp_red    = 3'b100;
    localparam logic [2:0] c_lamp_yellow = 3'b010;
    localparam logic [2:0] c_lamp_green  = 3'b001;

    localparam logic [1:0] c_ph_ns    = 2'd0;
    localparam logic [1:0] c_ph_ew    = 2'd1;
    localparam logic [1:0] c_ph_sw_ne = 2'd2;
    localparam logic [1:0] c_ph_wn_es = 2'd3;

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2,
        S_WALK    = 2'd3
    } state_t;

    // Packed lamp image, phase 0 in bits [2:0]; only GREEN/YELLOW light a non-red bus.
    function automatic logic [11:0] lamp_buses(state_t st, logic [1:0] ph);
        logic [11:0] lamps;
        lamps = {4{c_lamp_red}};
        if (st == S_GREEN)
            lamps[int'(ph)*3 +: 3] = c_lamp_green;
        else if (st == S_YELLOW)
            lamps[int'(ph)*3 +: 3] = c_lamp_yellow;
        return lamps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intersection_phase_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | intersection_phase_scheduler_if                                      |
// | Sensor/emergency inputs and lamp-driver outputs of the scheduler.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface intersection_phase_scheduler_if;

    logic       ns_traffic;
    logic       ew_traffic;
    logic       sw_ne_traffic;
    logic       wn_es_traffic;
    logic       ped_req;
    logic       emerg_valid;
    logic [1:0] emerg_dir;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] sw_ne_light;
    logic [2:0] wn_es_light;
    logic       ped_walk;
    logic [1:0] cur_phase;

    modport master (
        output ns_traffic, ew_traffic, sw_ne_traffic, wn_es_traffic,
        output ped_req, emerg_valid, emerg_dir,
        input  ns_light, ew_light, sw_ne_light, wn_es_light,
        input  ped_walk, cur_phase
    );

    modport slave (
        input  ns_traffic, ew_traffic, sw_ne_traffic, wn_es_traffic,
        input  ped_req, emerg_valid, emerg_dir,
        output ns_light, ew_light, sw_ne_light, wn_es_light,
        output ped_walk, cur_phase
    );

endinterface
`default_nettype wire

// File: rtl/intersection_phase_scheduler_rr_pick4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick4                                                             |
// | Picks the first asserted request at or after ptr, wrapping mod 4.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] w_cand;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        valid  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int k = 3; k >= 0; k--) begin
            w_cand = ptr + 2'(k);
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/intersection_phase_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | intersection_phase_scheduler                                         |
// | Round-robin 4-phase signal controller with ped walk and preemption.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module intersection_phase_scheduler
    import intersection_phase_scheduler_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3,
    parameter int TW        = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    intersection_phase_scheduler_if.slave   bus
);

    localparam logic [TW-1:0] c_green_min = TW'(GREEN_MIN);
    localparam logic [TW-1:0] c_green_max = TW'(GREEN_MAX);
    localparam logic [TW-1:0] c_yellow_t  = TW'(YELLOW_T);
    localparam logic [TW-1:0] c_allred_t  = TW'(ALLRED_T);
    localparam logic [TW-1:0] c_walk_t    = TW'(WALK_T);
    localparam logic [TW-1:0] c_one       = TW'(1);
    localparam logic [11:0]   c_all_red   = {4{c_lamp_red}};

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] r_green_cnt;
    logic [1:0]    r_phase;
    logic [1:0]    r_rr_ptr;
    logic          r_ped_latch;
    logic          r_preempt;
    logic [11:0]   r_lamps;
    logic          r_ped_walk;

    logic [3:0]    w_req;
    logic          w_pick_valid;
    logic [1:0]    w_pick_idx;
    logic          w_timer_done;
    logic          w_own_req;
    logic          w_other_req;
    logic          w_min_met;
    logic          w_max_hit;
    logic          w_emerg_elsewhere;
    logic          w_normal_end;
    logic          w_green_end;

    assign w_req = {bus.wn_es_traffic, bus.sw_ne_traffic, bus.ew_traffic, bus.ns_traffic};

    rr_pick4 u_rr_pick4 (
        .req   (w_req),
        .ptr   (r_rr_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_timer_done      = (r_timer == c_one);
    assign w_own_req         = w_req[r_phase];
    assign w_other_req       = |(w_req & ~(4'b0001 << r_phase));
    assign w_min_met         = (r_green_cnt >= c_green_min);
    assign w_max_hit         = (r_green_cnt == c_green_max);
    assign w_emerg_elsewhere = bus.emerg_valid && (bus.emerg_dir != r_phase);

    // Normal termination is suppressed while an emergency targets this phase.
    assign w_normal_end = !r_preempt && !bus.emerg_valid &&
                          (w_max_hit || (w_min_met && (w_other_req || r_ped_latch || !w_own_req)));
    assign w_green_end  = w_emerg_elsewhere || (r_preempt && !bus.emerg_valid) || w_normal_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_ALL_RED;
            r_timer     <= c_allred_t;
            r_green_cnt <= '0;
            r_phase     <= c_ph_ns;
            r_rr_ptr    <= c_ph_ns;
            r_ped_latch <= 1'b0;
            r_preempt   <= 1'b0;
            r_lamps     <= c_all_red;
            r_ped_walk  <= 1'b0;
        end else begin
            r_ped_latch <= r_ped_latch | bus.ped_req;
            unique case (r_state)
                S_ALL_RED: begin
                    if (!w_timer_done) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (bus.emerg_valid) begin
                        r_state     <= S_GREEN;
                        r_phase     <= bus.emerg_dir;
                        r_preempt   <= 1'b1;
                        r_green_cnt <= c_one;
                        r_lamps     <= lamp_buses(S_GREEN, bus.emerg_dir);
                    end else if (r_ped_latch) begin
                        r_state     <= S_WALK;
                        r_timer     <= c_walk_t;
                        r_ped_latch <= bus.ped_req;
                        r_ped_walk  <= 1'b1;
                        r_lamps     <= c_all_red;
                    end else if (w_pick_valid) begin
                        r_state     <= S_GREEN;
                        r_phase     <= w_pick_idx;
                        r_preempt   <= 1'b0;
                        r_green_cnt <= c_one;
                        r_lamps     <= lamp_buses(S_GREEN, w_pick_idx);
                    end
                end
                S_GREEN: begin
                    if (w_green_end) begin
                        r_state <= S_YELLOW;
                        r_timer <= c_yellow_t;
                        r_lamps <= lamp_buses(S_YELLOW, r_phase);
                    end else begin
                        if (bus.emerg_valid)
                            r_preempt <= 1'b1;
                        // Saturate so an indefinite preempted green cannot wrap.
                        if (r_green_cnt != c_green_max)
                            r_green_cnt <= r_green_cnt + 1'b1;
                    end
                end
                S_YELLOW: begin
                    if (w_timer_done) begin
                        r_state   <= S_ALL_RED;
                        r_timer   <= c_allred_t;
                        r_rr_ptr  <= r_phase + 2'd1;
                        r_preempt <= 1'b0;
                        r_lamps   <= c_all_red;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_WALK: begin
                    if (w_timer_done) begin
                        r_state    <= S_ALL_RED;
                        r_timer    <= c_allred_t;
                        r_ped_walk <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_ALL_RED;
                    r_timer <= c_allred_t;
                    r_lamps <= c_all_red;
                end
            endcase
        end
    end

    assign bus.ns_light    = r_lamps[2:0];
    assign bus.ew_light    = r_lamps[5:3];
    assign bus.sw_ne_light = r_lamps[8:6];
    assign bus.wn_es_light = r_lamps[11:9];
    assign bus.ped_walk    = r_ped_walk;
    assign bus.cur_phase   = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_intersection_phase_scheduler                                      |
// | Scenario-driven bench with an expected-trace scoreboard.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_intersection_phase_scheduler;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [14:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    intersection_phase_scheduler_if bus_if ();

    intersection_phase_scheduler #(
        .GREEN_MIN (4),
        .GREEN_MAX (10),
        .YELLOW_T  (2),
        .ALLRED_T  (1),
        .WALK_T    (3),
        .TW        (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected snapshot {ns, ew, sw_ne, wn_es, ped_walk, cur_phase}; ph<0 means all red.
    function automatic logic [14:0] snap(int ph, logic [2:0] col, logic walk, logic [1:0] cur);
        logic [11:0] l;
        for (int i = 0; i < 4; i++)
            l[11-3*i -: 3] = (i == ph) ? col : RED;
        return {l, walk, cur};
    endfunction

    task automatic expect_n(string tag, int n, int ph, logic [2:0] col, logic walk, logic [1:0] cur);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(snap(ph, col, walk, cur));
            tag_q.push_back(tag);
        end
    endtask

    task automatic tick();
        logic [14:0] got;
        int          nonred;
        @(posedge clk);
        #1;
        got = {bus_if.ns_light, bus_if.ew_light, bus_if.sw_ne_light, bus_if.wn_es_light,
               bus_if.ped_walk, bus_if.cur_phase};
        nonred = 0;
        if (bus_if.ns_light    != RED) nonred++;
        if (bus_if.ew_light    != RED) nonred++;
        if (bus_if.sw_ne_light != RED) nonred++;
        if (bus_if.wn_es_light != RED) nonred++;
        check("one_nonred", (nonred <= 1) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0)
            check(tag_q.pop_front(), 32'(got), 32'(exp_q.pop_front()));
    endtask

    task automatic drain(string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tag_q.delete();
    endtask

    task automatic clear_inputs();
        bus_if.ns_traffic    = 1'b0;
        bus_if.ew_traffic    = 1'b0;
        bus_if.sw_ne_traffic = 1'b0;
        bus_if.wn_es_traffic = 1'b0;
        bus_if.ped_req       = 1'b0;
        bus_if.emerg_valid   = 1'b0;
        bus_if.emerg_dir     = 2'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        expect_n("reset", 1, -1, RED, 1'b0, 2'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();

        // Idle: nothing requested, intersection stays all red.
        do_reset();
        expect_n("idle", 20, -1, RED, 1'b0, 2'd0);
        repeat (20) tick();
        drain("idle_drain");

        // Lone NS request: max green, yellow, clearance, regrant.
        do_reset();
        expect_n("ns_max_green", 10, 0, GRN, 1'b0, 2'd0);
        expect_n("ns_yellow", 2, 0, YEL, 1'b0, 2'd0);
        expect_n("ns_allred", 1, -1, RED, 1'b0, 2'd0);
        expect_n("ns_regrant", 3, 0, GRN, 1'b0, 2'd0);
        bus_if.ns_traffic = 1'b1;
        repeat (16) tick();
        drain("ns_drain");

        // All four requesting: round robin at minimum green.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            expect_n("rr_green", 4, p, GRN, 1'b0, 2'(p));
            expect_n("rr_yellow", 2, p, YEL, 1'b0, 2'(p));
            expect_n("rr_allred", 1, -1, RED, 1'b0, 2'(p));
        end
        expect_n("rr_wrap", 1, 0, GRN, 1'b0, 2'd0);
        bus_if.ns_traffic    = 1'b1;
        bus_if.ew_traffic    = 1'b1;
        bus_if.sw_ne_traffic = 1'b1;
        bus_if.wn_es_traffic = 1'b1;
        repeat (29) tick();
        drain("rr_drain");

        // Pedestrian pulse during NS green with EW waiting.
        do_reset();
        expect_n("ped_ns_green", 4, 0, GRN, 1'b0, 2'd0);
        expect_n("ped_ns_yellow", 2, 0, YEL, 1'b0, 2'd0);
        expect_n("ped_allred1", 1, -1, RED, 1'b0, 2'd0);
        expect_n("ped_walk", 3, -1, RED, 1'b1, 2'd0);
        expect_n("ped_allred2", 1, -1, RED, 1'b0, 2'd0);
        expect_n("ped_ew_green", 2, 1, GRN, 1'b0, 2'd1);
        bus_if.ns_traffic = 1'b1;
        bus_if.ew_traffic = 1'b1;
        tick();
        bus_if.ped_req = 1'b1;
        tick();
        bus_if.ped_req = 1'b0;
        repeat (11) tick();
        drain("ped_drain");

        // Emergency to SW_NE during EW green, held past max green.
        do_reset();
        expect_n("em_ew_green", 2, 1, GRN, 1'b0, 2'd1);
        expect_n("em_ew_yellow", 2, 1, YEL, 1'b0, 2'd1);
        expect_n("em_allred1", 1, -1, RED, 1'b0, 2'd1);
        expect_n("em_sw_hold", 12, 2, GRN, 1'b0, 2'd2);
        expect_n("em_sw_yellow", 2, 2, YEL, 1'b0, 2'd2);
        expect_n("em_allred2", 1, -1, RED, 1'b0, 2'd2);
        expect_n("em_wn_green", 2, 3, GRN, 1'b0, 2'd3);
        bus_if.ew_traffic    = 1'b1;
        bus_if.wn_es_traffic = 1'b1;
        repeat (2) tick();
        bus_if.emerg_valid = 1'b1;
        bus_if.emerg_dir   = 2'd2;
        repeat (15) tick();
        bus_if.emerg_valid = 1'b0;
        repeat (5) tick();
        drain("em_drain");

        // Reset asserted in the middle of EW yellow.
        do_reset();
        expect_n("rst_ew_green", 4, 1, GRN, 1'b0, 2'd1);
        expect_n("rst_ew_yellow", 1, 1, YEL, 1'b0, 2'd1);
        bus_if.ew_traffic    = 1'b1;
        bus_if.wn_es_traffic = 1'b1;
        repeat (5) tick();
        drain("rst_pre_drain");
        do_reset();
        expect_n("rst_after", 2, -1, RED, 1'b0, 2'd0);
        repeat (2) tick();
        drain("rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
